tick_counter: RTL and testbench

TICK_COUNTER -- requirements
Module: tick_counter

---
 rtl/tick_counter.sv | 59 +++++
 tb/tb_tick_counter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/tick_counter.sv
// tick_counter: prescaled up/down counter with wrap/clamp bounds, load, tick/terminal pulses and div_out square wave
// Ports: clock, reset (sync, active-high); enable, dir (1=up), saturate (1=clamp), load, load_value in;
//        count (registered value), tick (step pulse), terminal (step at a bound), div_out (~50% at TICK_HZ) out.
module tick_counter #(
  parameter int CLK_HZ    = 12000000,
  parameter int TICK_HZ   = 6,
  parameter int WIDTH     = 5,
  parameter int MAX_COUNT = 2**WIDTH-1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             dir,
  input  logic             saturate,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             terminal,
  output logic             div_out
);
  localparam int DIVISOR = CLK_HZ / TICK_HZ;
  localparam int PW = $clog2(DIVISOR);
  localparam logic [WIDTH-1:0] MAXC = WIDTH'(MAX_COUNT);
  logic [PW-1:0] pre_q, pre_d;
  logic [WIDTH-1:0] count_q, count_d, up_v, dn_v;
  logic tick_q, tick_d, terminal_q, terminal_d, div_q, div_d, step, at_bound;
  always_comb begin
    step = enable && pre_q == PW'(DIVISOR-1);
    at_bound = dir ? count_q == MAXC : count_q == '0;
    up_v = count_q == MAXC ? (saturate ? MAXC : '0) : count_q + 1'b1;
    dn_v = count_q == '0 ? (saturate ? '0 : MAXC) : count_q - 1'b1;
    pre_d = load || step ? '0 : enable ? pre_q + 1'b1 : pre_q;
    count_d = load ? (load_value > MAXC ? MAXC : load_value) : step ? (dir ? up_v : dn_v) : count_q;
    // a load on a step edge suppresses the step entirely, including its pulses
    tick_d = step && !load;
    terminal_d = step && !load && at_bound;
    div_d = pre_q < PW'(DIVISOR/2);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      pre_q <= '0;
      count_q <= '0;
      tick_q <= 1'b0;
      terminal_q <= 1'b0;
      div_q <= 1'b0;
    end else begin
      pre_q <= pre_d;
      count_q <= count_d;
      tick_q <= tick_d;
      terminal_q <= terminal_d;
      div_q <= div_d;
    end
  end
  assign count = count_q;
  assign tick = tick_q;
  assign terminal = terminal_q;
  assign div_out = div_q;
endmodule

// File: tb/tb_tick_counter.sv
// tb_tick_counter: randomized and directed checks of tick_counter against a behavioural model
module tb_tick_counter;
  localparam int DIV = 4;
  localparam int MAXC = 5;
  logic clock = 1'b0, reset = 1'b1, enable = 1'b0, dir = 1'b0, saturate = 1'b0, load = 1'b0;
  logic [2:0] load_value = '0;
  logic [2:0] count;
  logic tick, terminal, div_out;
  int m_pre, m_cnt, checks, errors;
  logic m_tick, m_term, m_div;
  tick_counter #(.CLK_HZ(8), .TICK_HZ(2), .WIDTH(3), .MAX_COUNT(5)) dut (
    .clock(clock), .reset(reset), .enable(enable), .dir(dir), .saturate(saturate),
    .load(load), .load_value(load_value), .count(count), .tick(tick),
    .terminal(terminal), .div_out(div_out)
  );
  always #5 clock = ~clock;
  task automatic clk_step;
    @(posedge clock);
    if (reset) begin
      m_pre = 0; m_cnt = 0; m_tick = 0; m_term = 0; m_div = 0;
    end else begin
      m_div = m_pre < DIV / 2;
      m_tick = 0;
      m_term = 0;
      if (load) begin
        m_cnt = load_value > MAXC ? MAXC : int'(load_value);
        m_pre = 0;
      end else if (enable && m_pre == DIV - 1) begin
        m_pre = 0;
        m_tick = 1;
        m_term = dir ? m_cnt == MAXC : m_cnt == 0;
        if (saturate) m_cnt = dir ? (m_cnt == MAXC ? MAXC : m_cnt + 1) : (m_cnt == 0 ? 0 : m_cnt - 1);
        else m_cnt = dir ? (m_cnt + 1) % (MAXC + 1) : (m_cnt + MAXC) % (MAXC + 1);
      end else if (enable) m_pre++;
    end
    #1;
  endtask
  task automatic test_reset;
    reset = 1; load = 1; load_value = 3; enable = 1;
    clk_step; clk_step;
    checks++;
    if ({count, tick, terminal, div_out} !== 6'b0) begin
      errors++; $display("FAIL reset_state: got cnt=%0d tick=%b term=%b div=%b exp all 0", count, tick, terminal, div_out);
    end
    load = 0;
  endtask
  task automatic test_count_up;
    int exp_seq[7] = '{1, 2, 3, 4, 5, 0, 1};
    int k = 0;
    reset = 1; clk_step;
    reset = 0; enable = 1; dir = 1; saturate = 0;
    for (int i = 1; i <= 28; i++) begin
      clk_step;
      checks++;
      if ({count, tick, terminal, div_out} !== {3'(m_cnt), m_tick, m_term, m_div}) begin
        errors++; $display("FAIL up_model c%0d: got %0d/%b/%b/%b exp %0d/%b/%b/%b", i, count, tick, terminal, div_out, m_cnt, m_tick, m_term, m_div);
      end
      checks++;
      if (tick !== (i % 4 == 0)) begin
        errors++; $display("FAIL up_tick_period c%0d: got tick=%b exp %b", i, tick, i % 4 == 0);
      end
      if (tick === 1'b1 && k < 7) begin
        checks++;
        if (count !== 3'(exp_seq[k]) || terminal !== (k == 5)) begin
          errors++; $display("FAIL up_seq k%0d: got cnt=%0d term=%b exp cnt=%0d term=%b", k, count, terminal, exp_seq[k], k == 5);
        end
        k++;
      end
    end
    checks++;
    if (k != 7) begin
      errors++; $display("FAIL up_tick_count: got %0d exp 7", k);
    end
  endtask
  task automatic test_saturate_up;
    int k = 0;
    load = 1; load_value = 7; clk_step; load = 0;
    checks++;
    if (count !== 3'd5 || tick !== 1'b0) begin
      errors++; $display("FAIL load_clamp: got cnt=%0d tick=%b exp cnt=5 tick=0", count, tick);
    end
    dir = 1; saturate = 1; enable = 1;
    for (int n = 0; n < 20 && k < 2; n++) begin
      clk_step;
      if (tick === 1'b1) begin
        checks++;
        if (count !== 3'd5 || terminal !== 1'b1) begin
          errors++; $display("FAIL sat_up k%0d: got cnt=%0d term=%b exp cnt=5 term=1", k, count, terminal);
        end
        k++;
      end
    end
    checks++;
    if (k != 2) begin
      errors++; $display("FAIL sat_up_ticks: got %0d exp 2", k);
    end
  endtask
  task automatic test_down;
    for (int s = 0; s < 2; s++) begin
      int k = 0;
      load = 1; load_value = 0; clk_step; load = 0;
      dir = 0; saturate = s[0]; enable = 1;
      for (int n = 0; n < 8 && k < 1; n++) begin
        clk_step;
        if (tick === 1'b1) begin
          checks++;
          if (count !== (s == 0 ? 3'd5 : 3'd0) || terminal !== 1'b1) begin
            errors++; $display("FAIL down_bound sat=%0d: got cnt=%0d term=%b exp cnt=%0d term=1", s, count, terminal, s == 0 ? 5 : 0);
          end
          k++;
        end
      end
      checks++;
      if (k != 1) begin
        errors++; $display("FAIL down_tick sat=%0d: got %0d ticks exp 1", s, k);
      end
    end
  endtask
  task automatic test_load_vs_step;
    load = 1; load_value = 0; clk_step; load = 0;
    enable = 1; dir = 1; saturate = 0;
    clk_step; clk_step; clk_step;
    load = 1; load_value = 3; clk_step; load = 0;
    checks++;
    if (count !== 3'd3 || tick !== 1'b0 || terminal !== 1'b0) begin
      errors++; $display("FAIL load_wins: got cnt=%0d tick=%b term=%b exp cnt=3 tick=0 term=0", count, tick, terminal);
    end
    for (int i = 1; i <= 4; i++) begin
      clk_step;
      checks++;
      if (tick !== (i == 4) || count !== (i == 4 ? 3'd4 : 3'd3)) begin
        errors++; $display("FAIL load_next_tick c%0d: got tick=%b cnt=%0d exp tick=%b cnt=%0d", i, tick, count, i == 4, i == 4 ? 4 : 3);
      end
    end
  endtask
  task automatic test_enable_hold;
    logic [2:0] c0;
    logic d0;
    load = 1; load_value = 2; clk_step; load = 0;
    enable = 1; dir = 1; saturate = 0;
    clk_step; clk_step;
    enable = 0; clk_step;
    c0 = count; d0 = div_out;
    checks++;
    if (c0 !== 3'd2 || d0 !== 1'b0) begin
      errors++; $display("FAIL hold_entry: got cnt=%0d div=%b exp cnt=2 div=0", c0, d0);
    end
    for (int i = 0; i < 9; i++) begin
      clk_step;
      checks++;
      if (count !== c0 || div_out !== d0 || tick !== 1'b0) begin
        errors++; $display("FAIL hold c%0d: got cnt=%0d div=%b tick=%b exp cnt=%0d div=%b tick=0", i, count, div_out, tick, c0, d0);
      end
    end
    enable = 1;
    for (int i = 1; i <= 2; i++) begin
      clk_step;
      checks++;
      if (tick !== (i == 2) || count !== (i == 2 ? 3'd3 : 3'd2)) begin
        errors++; $display("FAIL reenable c%0d: got tick=%b cnt=%0d exp tick=%b cnt=%0d", i, tick, count, i == 2, i == 2 ? 3 : 2);
      end
    end
  endtask
  task automatic test_reset_mid;
    load = 1; load_value = 4; clk_step; load = 0;
    enable = 1; dir = 1; saturate = 0;
    clk_step; clk_step; clk_step;
    checks++;
    if (count !== 3'd4 || tick !== 1'b0) begin
      errors++; $display("FAIL pre_reset: got cnt=%0d tick=%b exp cnt=4 tick=0", count, tick);
    end
    reset = 1; load = 1; load_value = 5; clk_step;
    reset = 0; load = 0;
    checks++;
    if ({count, tick, terminal, div_out} !== 6'b0) begin
      errors++; $display("FAIL reset_mid: got cnt=%0d tick=%b term=%b div=%b exp all 0", count, tick, terminal, div_out);
    end
    for (int i = 1; i <= 4; i++) begin
      clk_step;
      checks++;
      if (tick !== (i == 4)) begin
        errors++; $display("FAIL reset_first_tick c%0d: got tick=%b exp %b", i, tick, i == 4);
      end
    end
  endtask
  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      reset = $urandom_range(0, 49) == 0;
      load = $urandom_range(0, 9) == 0;
      enable = $urandom_range(0, 4) != 0;
      dir = $urandom_range(0, 1) == 1;
      saturate = $urandom_range(0, 1) == 1;
      load_value = 3'($urandom_range(0, 7));
      clk_step;
      checks++;
      if ({count, tick, terminal, div_out} !== {3'(m_cnt), m_tick, m_term, m_div}) begin
        errors++; $display("FAIL random c%0d: got %0d/%b/%b/%b exp %0d/%b/%b/%b", i, count, tick, terminal, div_out, m_cnt, m_tick, m_term, m_div);
      end
    end
    reset = 0; load = 0;
  endtask
  initial begin
    checks = 0; errors = 0;
    m_pre = 0; m_cnt = 0; m_tick = 0; m_term = 0; m_div = 0;
    test_reset;
    test_count_up;
    test_saturate_up;
    test_down;
    test_load_vs_step;
    test_enable_hold;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
